// File: rtl/parking_slot_manager.sv
// -----------------------------------------------------------------------------
// parking_slot_manager
//
// Sequential slot allocator for an 8-slot car park. It owns the free-slot
// vector. A car at the entry gets the lowest-numbered free slot, and the entry
// gate opens for GATE_CYCLES cycles. An exit report frees the named slot.
//
// Parameters
//   GATE_CYCLES      cycles gate_open stays high per admitted car (2..255)
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   entry            level, car present at the entry sensor
//   exit             one-cycle pulse, a car has left slot exit_slot
//   exit_slot        index of the slot being vacated (valid with exit)
//   parking_capacity registered free-slot vector, bit i = slot i free
//   full             high when no slot is free
//   gate_open        entry barrier drive
//   assigned_slot    slot given to the most recently admitted car (held)
//   assign_valid     one-cycle pulse when assigned_slot updates
//   exit_err         one-cycle pulse, exit named a slot that was already free
// -----------------------------------------------------------------------------
module parking_slot_manager #(
   parameter int GATE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       entry,
   input  logic       exit,
   input  logic [2:0] exit_slot,
   output logic [7:0] parking_capacity,
   output logic       full,
   output logic       gate_open,
   output logic [2:0] assigned_slot,
   output logic       assign_valid,
   output logic       exit_err
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      OPEN       = 2'd1,
      WAIT_CLEAR = 2'd2
   } state_t;

   localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES - 1);

   state_t     state_reg;
   logic [7:0] gate_cnt_reg;
   logic [7:0] cap_reg;
   logic [2:0] assigned_slot_reg;
   logic       assign_valid_reg;
   logic       exit_err_reg;
   logic       gate_open_reg;

   logic [8:0] below_free;   // below_free[i]: some slot with index < i is free
   logic [7:0] lowest_mask;  // one-hot mask of the lowest free slot
   logic [2:0] lowest_idx;
   logic       alloc_now;
   logic [7:0] alloc_mask;
   logic [7:0] exit_mask;
   logic [7:0] cap_next;

   // Priority chain that picks the lowest free slot as a one-hot mask.
   assign below_free[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lowest
         assign below_free[gi+1] = below_free[gi] | cap_reg[gi];
         assign lowest_mask[gi]  = cap_reg[gi] & ~below_free[gi];
      end
   endgenerate

   // The mask is one-hot (or zero), so OR-ing the indices encodes it.
   always_comb begin
      lowest_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (lowest_mask[i]) begin
            lowest_idx = lowest_idx | 3'(i);
         end
      end
   end

   assign alloc_now  = (state_reg == IDLE) && entry && (cap_reg != 8'h00);
   assign alloc_mask = alloc_now ? lowest_mask : 8'h00;

   // Only an occupied slot can be freed. An exit on a free slot is reported
   // through exit_err instead. Both masks come from the current register value,
   // so a slot freed this cycle is never handed out in the same cycle.
   assign exit_mask = (exit && !cap_reg[exit_slot]) ? (8'd1 << exit_slot) : 8'h00;
   assign cap_next  = (cap_reg & ~alloc_mask) | exit_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         gate_cnt_reg      <= 8'd0;
         cap_reg           <= 8'hFF;
         assigned_slot_reg <= 3'd0;
         assign_valid_reg  <= 1'b0;
         exit_err_reg      <= 1'b0;
         gate_open_reg     <= 1'b0;
      end else begin
         cap_reg          <= cap_next;
         exit_err_reg     <= exit && cap_reg[exit_slot];
         assign_valid_reg <= alloc_now;
         if (alloc_now) begin
            assigned_slot_reg <= lowest_idx;
         end

         case (state_reg)
            IDLE: begin
               if (alloc_now) begin
                  gate_cnt_reg  <= GATE_LOAD;
                  gate_open_reg <= 1'b1;
                  state_reg     <= OPEN;
               end
            end
            OPEN: begin
               // The gate is already high in the cycle the counter is loaded,
               // so it stays high for GATE_CYCLES cycles in total.
               if (gate_cnt_reg == 8'd0) begin
                  gate_open_reg <= 1'b0;
                  state_reg     <= WAIT_CLEAR;
               end else begin
                  gate_cnt_reg <= gate_cnt_reg - 8'd1;
               end
            end
            WAIT_CLEAR: begin
               // The sensor must be seen clear once, so a held entry admits
               // only one car.
               if (!entry) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               gate_open_reg <= 1'b0;
            end
         endcase
      end
   end

   assign parking_capacity = cap_reg;
   assign full             = (cap_reg == 8'h00);
   assign gate_open        = gate_open_reg;
   assign assigned_slot    = assigned_slot_reg;
   assign assign_valid     = assign_valid_reg;
   assign exit_err         = exit_err_reg;

endmodule

// File: tb/tb_parking_slot_manager.sv
// -----------------------------------------------------------------------------
// Testbench for parking_slot_manager.
// A behavioural model keeps the set of free slots as an array, the gate as a
// remaining-time count, and an "entry seen clear" flag. Every cycle, all DUT
// outputs are compared with the model. Directed scenarios add explicit checks
// against fixed values, and then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_parking_slot_manager;

   localparam int G = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       entry;
   logic       exit;
   logic [2:0] exit_slot;
   logic [7:0] parking_capacity;
   logic       full;
   logic       gate_open;
   logic [2:0] assigned_slot;
   logic       assign_valid;
   logic       exit_err;

   parking_slot_manager #(.GATE_CYCLES(G)) dut (
      .clk              (clk),
      .rst              (rst),
      .entry            (entry),
      .exit             (exit),
      .exit_slot        (exit_slot),
      .parking_capacity (parking_capacity),
      .full             (full),
      .gate_open        (gate_open),
      .assigned_slot    (assigned_slot),
      .assign_valid     (assign_valid),
      .exit_err         (exit_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int av_seen  = 0;
   int gate_seen = 0;

   // Reference model state
   bit         m_free [8];
   int         m_gate_left;
   bit         m_ready;
   logic [2:0] m_assigned;
   bit         m_av;
   bit         m_err;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_cap();
      logic [7:0] c;
      for (int i = 0; i < 8; i++) c[i] = m_free[i];
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_free[i] = 1'b1;
      m_gate_left = 0;
      m_ready     = 1'b1;
      m_assigned  = 3'd0;
      m_av        = 1'b0;
      m_err       = 1'b0;
   endtask

   // One clock edge of the specification's rules, applied to the pre-edge state.
   task automatic model_edge(input bit e, input bit x, input logic [2:0] s, input bit r);
      bit any_free;
      int k;
      bit admit;
      int old_gate;
      if (r) begin
         model_reset();
         return;
      end
      any_free = 1'b0;
      k = 0;
      for (int i = 7; i >= 0; i--) begin
         if (m_free[i]) begin
            any_free = 1'b1;
            k = i;
         end
      end
      admit    = m_ready && e && any_free;
      old_gate = m_gate_left;
      m_err    = x && m_free[s];
      m_av     = admit;
      if (x && !m_free[s]) m_free[s] = 1'b1;
      if (admit) begin
         m_free[k]   = 1'b0;
         m_assigned  = 3'(k);
         m_gate_left = G;
         m_ready     = 1'b0;
      end else begin
         if (m_gate_left > 0) m_gate_left--;
         if (!m_ready && old_gate == 0 && !e) m_ready = 1'b1;
      end
   endtask

   task automatic compare_all();
      check_val("capacity", parking_capacity, m_cap());
      check_val("full", full, (m_cap() == 8'h00));
      check_val("gate_open", gate_open, (m_gate_left > 0));
      check_val("assign_valid", assign_valid, m_av);
      check_val("assigned_slot", assigned_slot, m_assigned);
      check_val("exit_err", exit_err, m_err);
      if (assign_valid === 1'b1) begin
         av_seen++;
         $display("alloc slot=%0d capacity=%02h t=%0t", assigned_slot, parking_capacity, $time);
      end
      if (exit_err === 1'b1)
         $display("exit_err capacity=%02h t=%0t", parking_capacity, $time);
      if (gate_open === 1'b1) gate_seen++;
   endtask

   task automatic step(input bit e, input bit x, input logic [2:0] s, input bit r);
      entry     = e;
      exit      = x;
      exit_slot = s;
      rst       = r;
      @(posedge clk);
      model_edge(e, x, s, r);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   initial begin
      bit e_r;
      model_reset();
      entry = 0; exit = 0; exit_slot = 0; rst = 1;

      // Reset values, then entry held for 40 cycles
      do_reset();
      check_val("rst_capacity", parking_capacity, 8'hFF);
      check_val("rst_gate", gate_open, 1'b0);
      check_val("rst_full", full, 1'b0);
      av_seen = 0; gate_seen = 0;
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 3'd0, 1'b0);
      check_val("hold_av_count", av_seen, 1);
      check_val("hold_gate_cycles", gate_seen, G);
      check_val("hold_capacity", parking_capacity, 8'hFE);
      check_val("hold_slot", assigned_slot, 3'd0);
      idle(3);

      // Eight separate entries fill the park
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 3'd0, 1'b0);
         check_val("seq_slot", assigned_slot, i);
         idle(20);
      end
      check_val("full_capacity", parking_capacity, 8'h00);
      check_val("full_flag", full, 1'b1);
      av_seen = 0; gate_seen = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd0, 1'b0);
      check_val("ninth_av", av_seen, 0);
      check_val("ninth_gate", gate_seen, 0);
      idle(2);

      // Exit slot 5 from a full park, then slot 5 is reused
      step(1'b0, 1'b1, 3'd5, 1'b0);
      check_val("exit5_capacity", parking_capacity, 8'h20);
      check_val("exit5_full", full, 1'b0);
      step(1'b1, 1'b0, 3'd0, 1'b0);
      check_val("reuse_slot", assigned_slot, 3'd5);
      idle(20);

      // Exit on an already free slot
      do_reset();
      step(1'b0, 1'b1, 3'd2, 1'b0);
      check_val("err_pulse", exit_err, 1'b1);
      check_val("err_capacity", parking_capacity, 8'hFF);
      idle(1);
      check_val("err_one_cycle", exit_err, 1'b0);

      // Simultaneous allocation and exit at capacity F0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 3'd0, 1'b0);
         idle(20);
      end
      check_val("pre_capacity", parking_capacity, 8'hF0);
      step(1'b1, 1'b1, 3'd1, 1'b0);
      check_val("simul_slot", assigned_slot, 3'd4);
      check_val("simul_capacity", parking_capacity, 8'hE2);
      idle(20);

      // Reset while the gate is open
      do_reset();
      step(1'b1, 1'b0, 3'd0, 1'b0);
      idle(3);
      check_val("open_gate", gate_open, 1'b1);
      step(1'b1, 1'b0, 3'd0, 1'b1);
      check_val("midrst_gate", gate_open, 1'b0);
      check_val("midrst_capacity", parking_capacity, 8'hFF);
      idle(1);
      step(1'b1, 1'b0, 3'd0, 1'b0);
      check_val("midrst_slot", assigned_slot, 3'd0);
      check_val("midrst_av", assign_valid, 1'b1);
      idle(20);

      // Randomized traffic
      e_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) e_r = ~e_r;
         step(e_r, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 599) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
